// File: rtl/genie_split_mc_pkg.sv
// Shared defaults for the multicast split node.
package genie_split_mc_pkg;
  localparam int unsigned DEF_NO    = 2;
  localparam int unsigned DEF_WIDTH = 8;
endpackage

// File: rtl/genie_split_mc_slot.sv
// Single held beat with per-output pending bits; drains as outputs accept.
module genie_split_mc_slot
  import genie_split_mc_pkg::*;
#(
  parameter int unsigned NO    = DEF_NO,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_eop,
  input  logic [NO-1:0]    ld_mask,
  input  logic [NO-1:0]    i_ready,
  output logic [NO-1:0]    o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_eop,
  output logic             drain_c
);

  logic [NO-1:0] pend;

  assign o_valid = pend;
  assign drain_c = (pend & ~i_ready) == '0;

  // A load replaces the pending set outright, so a new beat wins over the drain clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend   <= '0;
      o_data <= '0;
      o_eop  <= 1'b0;
    end else if (load) begin
      pend   <= ld_mask;
      o_data <= ld_data;
      o_eop  <= ld_eop;
    end else begin
      pend   <= pend & ~i_ready;
    end
  end

endmodule

// File: rtl/genie_split_mc.sv
// Multicast split: one stream in, each beat copied to the outputs in its packet's mask.
module genie_split_mc
  import genie_split_mc_pkg::*;
#(
  parameter int unsigned NO    = DEF_NO,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_eop,
  input  logic [NO-1:0]    i_mask,
  output logic [NO-1:0]    o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_eop,
  input  logic [NO-1:0]    i_ready
);

  logic          in_pkt;
  logic [NO-1:0] pkt_mask;
  logic [NO-1:0] eff_mask_c;
  logic          drain_c;
  logic          xfer_c;

  assign o_ready    = reset & drain_c;
  assign xfer_c     = i_valid & o_ready;
  assign eff_mask_c = in_pkt ? pkt_mask : i_mask;

  genie_split_mc_slot #(.NO(NO), .WIDTH(WIDTH)) u_slot (
    .clk     (clk),
    .reset   (reset),
    .load    (xfer_c),
    .ld_data (i_data),
    .ld_eop  (i_eop),
    .ld_mask (eff_mask_c),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_eop   (o_eop),
    .drain_c (drain_c)
  );

  // Mask is latched on the first beat of a multi-beat packet and reused until eop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_pkt   <= 1'b0;
      pkt_mask <= '0;
    end else if (xfer_c) begin
      if (i_eop) begin
        in_pkt <= 1'b0;
      end else if (!in_pkt) begin
        in_pkt   <= 1'b1;
        pkt_mask <= i_mask;
      end
    end
  end

endmodule

// File: tb/tb_genie_split_mc.sv
// Scoreboard bench for genie_split_mc with four outputs.
module tb_genie_split_mc;
  localparam int unsigned NO    = 4;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic             i_eop;
  logic [NO-1:0]    i_mask;
  logic [NO-1:0]    o_valid;
  logic [WIDTH-1:0] o_data;
  logic             o_eop;
  logic [NO-1:0]    i_ready;

  genie_split_mc #(.NO(NO), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_eop   (i_eop),
    .i_mask  (i_mask),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_eop   (o_eop),
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int accepted = 0;
  logic last_ready;

  logic [NO-1:0] m_pend;
  logic          m_in_pkt;
  logic [NO-1:0] m_pkt;
  logic [WIDTH:0] sb_q [NO][$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, account transfers, advance.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic e,
                       input logic [NO-1:0] mask, input logic [NO-1:0] rdy);
    logic          mrdy;
    logic [NO-1:0] em;
    logic [WIDTH:0] exp_beat;
    i_valid = v;
    i_data  = d;
    i_eop   = e;
    i_mask  = mask;
    i_ready = rdy;
    #1;
    mrdy = ((m_pend & ~rdy) == '0);
    check("o_valid", 32'(o_valid), 32'(m_pend));
    check("o_ready", 32'(o_ready), 32'(mrdy));
    last_ready = o_ready;
    for (int k = 0; k < int'(NO); k++) begin
      if (m_pend[k] && rdy[k]) begin
        if (sb_q[k].size() == 0) begin
          check("sb_underflow", 32'(k), 32'hFFFF_FFFF);
        end else begin
          exp_beat = sb_q[k].pop_front();
          check("out_beat", 32'({o_eop, o_data}), 32'(exp_beat));
        end
      end
    end
    m_pend = m_pend & ~rdy;
    if (v && mrdy) begin
      em = m_in_pkt ? m_pkt : mask;
      for (int k = 0; k < int'(NO); k++)
        if (em[k]) sb_q[k].push_back({e, d});
      m_pend = em;
      accepted++;
      if (e) m_in_pkt = 1'b0;
      else if (!m_in_pkt) begin
        m_in_pkt = 1'b1;
        m_pkt    = mask;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int start;
    reset   = 1'b0;
    i_valid = 1'b1;
    i_data  = 8'hFF;
    i_eop   = 1'b0;
    i_mask  = 4'hF;
    i_ready = 4'hF;
    m_pend   = '0;
    m_in_pkt = 1'b0;
    m_pkt    = '0;

    // Reset: held beat offered but refused.
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_ready", 32'(o_ready), 32'd0);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_data",  32'(o_data),  32'd0);
    check("rst_o_eop",   32'(o_eop),   32'd0);
    reset = 1'b1;
    #1;
    check("rel_o_ready", 32'(o_ready), 32'd1);

    // Single beat to 1011, all ready.
    cycle(1'b1, 8'hA5, 1'b1, 4'b1011, 4'hF);
    check("sb_valid", 32'(o_valid), 32'b1011);
    check("sb_data",  32'(o_data),  32'hA5);
    cycle(1'b0, 8'h00, 1'b0, 4'h0, 4'hF);
    check("sb_drained", 32'(o_valid), 32'b0000);

    // Staggered drain with a new beat on the releasing cycle.
    cycle(1'b1, 8'h3C, 1'b1, 4'b1011, 4'hF);
    check("stag_v0", 32'(o_valid), 32'b1011);
    cycle(1'b1, 8'hC3, 1'b1, 4'b0100, 4'b0001);
    check("stag_r1", 32'(last_ready), 32'd0);
    check("stag_v1", 32'(o_valid), 32'b1010);
    cycle(1'b1, 8'hC3, 1'b1, 4'b0100, 4'b1000);
    check("stag_r2", 32'(last_ready), 32'd0);
    check("stag_v2", 32'(o_valid), 32'b0010);
    cycle(1'b1, 8'h77, 1'b1, 4'b0100, 4'b0010);
    check("stag_r3", 32'(last_ready), 32'd1);
    check("stag_v3", 32'(o_valid), 32'b0100);
    check("stag_d3", 32'(o_data), 32'h77);
    cycle(1'b0, 8'h00, 1'b0, 4'h0, 4'hF);

    // Multi-beat packet keeps its first-beat mask.
    cycle(1'b1, 8'h11, 1'b0, 4'b0110, 4'hF);
    check("pkt_b0", 32'(o_valid), 32'b0110);
    cycle(1'b1, 8'h22, 1'b0, 4'b1001, 4'hF);
    check("pkt_b1", 32'(o_valid), 32'b0110);
    cycle(1'b1, 8'h33, 1'b1, 4'b1001, 4'hF);
    check("pkt_b2", 32'(o_valid), 32'b0110);
    check("pkt_eop", 32'(o_eop), 32'd1);
    cycle(1'b1, 8'h44, 1'b1, 4'b1001, 4'hF);
    check("pkt_next", 32'(o_valid), 32'b1001);
    cycle(1'b0, 8'h00, 1'b0, 4'h0, 4'hF);

    // Zero mask drops the beat without stalling.
    cycle(1'b1, 8'h55, 1'b1, 4'b0000, 4'b0000);
    check("m0_valid", 32'(o_valid), 32'b0000);
    cycle(1'b1, 8'h66, 1'b1, 4'b0001, 4'b0000);
    check("m0_ready", 32'(last_ready), 32'd1);
    check("m0_next", 32'(o_valid), 32'b0001);
    cycle(1'b0, 8'h00, 1'b0, 4'h0, 4'hF);

    // Back-to-back with all ready: one beat per cycle.
    start = accepted;
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 8'(i * 17), 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 4'hF);
    check("b2b_beats", 32'(accepted - start), 32'd8);
    cycle(1'b0, 8'h00, 1'b0, 4'h0, 4'hF);

    // Random traffic.
    start = accepted;
    cyc = 0;
    while ((accepted - start) < 10000 && cyc < 80000) begin
      cycle(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 3) == 0),
            4'($urandom), {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)});
      cyc++;
    end
    check("rand_budget", 32'(accepted - start >= 10000), 32'd1);
    repeat (2) cycle(1'b0, 8'h00, 1'b0, 4'h0, 4'hF);
    for (int k = 0; k < int'(NO); k++)
      check("sb_leftover", 32'(sb_q[k].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
